hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-unit signal bundle: pipeline-register tags and controls in, stall/flush/forward decisions out.
interface hazard_ctrl_if;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] Rs1E;
    logic [4:0] Rs2E;
    logic [4:0] RdE;
    logic [4:0] RdM;
    logic [4:0] RdW;
    logic [1:0] ResultSrcE;
    logic       RegWriteM;
    logic       RegWriteW;
    logic       PCSrcE;
    logic       MulDivStartE;
    logic [5:0] MulDivLatE;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       FlushD;
    logic       FlushE;
    logic       FlushM;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       MulDivDoneE;
    logic       Busy;

    // Pipeline side: drives the register tags and controls, observes the decisions.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MulDivStartE, MulDivLatE,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
               ForwardAE, ForwardBE, MulDivDoneE, Busy
    );

    // Hazard unit side.
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MulDivStartE, MulDivLatE,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
               ForwardAE, ForwardBE, MulDivDoneE, Busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: load-use stall, branch flush, operand forwarding,
// and a multi-cycle mul/div sequencer that freezes the front end for L-1 cycles.
module hazard_ctrl #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       md_stall;
    logic       md_done;
    logic       lw_stall;
    logic [4:0] rs_e [2];

    // XLEN only sizes the surrounding datapath; reject nonsensical values at elaboration.
    if (XLEN <= 0) begin : g_bad_xlen
        $error("hazard_ctrl: XLEN must be positive");
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt holds the cycles still to go after the current one; done fires when it reaches 1.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_stall = 1'b0;
        md_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (hz.MulDivStartE) begin
                    if (hz.MulDivLatE >= 6'd2) begin
                        state_d  = BUSY;
                        cnt_d    = hz.MulDivLatE - 6'd1;
                        md_stall = 1'b1;
                    end else begin
                        md_done = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q > 6'd1) begin
                    cnt_d    = cnt_q - 6'd1;
                    md_stall = 1'b1;
                end else begin
                    md_done = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    assign lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    assign rs_e[0] = hz.Rs1E;
    assign rs_e[1] = hz.Rs2E;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_fwd
        logic [1:0] sel;
        always_comb begin
            sel = 2'b00;
            if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == rs_e[gi])) begin
                sel = 2'b10;
            end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == rs_e[gi])) begin
                sel = 2'b01;
            end
        end
    end

    // Every output is forced low while reset is held, including the combinational paths.
    always_comb begin
        hz.StallF      = 1'b0;
        hz.StallD      = 1'b0;
        hz.StallE      = 1'b0;
        hz.FlushD      = 1'b0;
        hz.FlushE      = 1'b0;
        hz.FlushM      = 1'b0;
        hz.ForwardAE   = 2'b00;
        hz.ForwardBE   = 2'b00;
        hz.MulDivDoneE = 1'b0;
        hz.Busy        = 1'b0;
        if (!reset) begin
            hz.StallF      = lw_stall | md_stall;
            hz.StallD      = lw_stall | md_stall;
            hz.StallE      = md_stall;
            hz.FlushM      = md_stall;
            hz.FlushD      = hz.PCSrcE & ~md_stall;
            hz.FlushE      = (lw_stall | hz.PCSrcE) & ~md_stall;
            hz.ForwardAE   = g_fwd[0].sel;
            hz.ForwardBE   = g_fwd[1].sel;
            hz.MulDivDoneE = md_done;
            hz.Busy        = (state_q == BUSY);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl; a cycle-level reference model feeds a scoreboard queue.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rsrc;
        logic       rwm, rww, pcsrc, start;
        logic [5:0] lat;
    } stim_t;

    typedef struct packed {
        logic       sf, sd, se, fd, fe, fm;
        logic [1:0] fa, fb;
        logic       done, busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    hazard_ctrl_if hz ();

    hazard_ctrl #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   cyc_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   md_left = 0;   // cycles the in-flight mul/div op still occupies, counting the current one
    bit   drv_done = 1'b0;

    function automatic logic [1:0] fwd_ref(logic [4:0] rs, logic rwm, logic [4:0] rdm,
                                           logic rww, logic [4:0] rdw);
        if (rs != 5'd0 && rwm && rdm == rs) return 2'b10;
        if (rs != 5'd0 && rww && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t quiet();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        int   rem;
        logic busy, md, lw;
        @(posedge clk);
        #1;
        reset           = s.rst;
        hz.Rs1D         = s.rs1d;
        hz.Rs2D         = s.rs2d;
        hz.Rs1E         = s.rs1e;
        hz.Rs2E         = s.rs2e;
        hz.RdE          = s.rde;
        hz.RdM          = s.rdm;
        hz.RdW          = s.rdw;
        hz.ResultSrcE   = s.rsrc;
        hz.RegWriteM    = s.rwm;
        hz.RegWriteW    = s.rww;
        hz.PCSrcE       = s.pcsrc;
        hz.MulDivStartE = s.start;
        hz.MulDivLatE   = s.lat;
        e = '0;
        if (s.rst) begin
            md_left = 0;
        end else begin
            busy = (md_left > 0);
            if (busy)         rem = md_left;
            else if (s.start) rem = (s.lat <= 6'd1) ? 1 : int'(s.lat);
            else              rem = 0;
            md = (rem > 1);
            lw = (s.rsrc == 2'b01) && (s.rde != 5'd0) && (s.rde == s.rs1d || s.rde == s.rs2d);
            e.sf   = lw | md;
            e.sd   = lw | md;
            e.se   = md;
            e.fm   = md;
            e.fd   = s.pcsrc & ~md;
            e.fe   = (lw | s.pcsrc) & ~md;
            e.fa   = fwd_ref(s.rs1e, s.rwm, s.rdm, s.rww, s.rdw);
            e.fb   = fwd_ref(s.rs2e, s.rwm, s.rdm, s.rww, s.rdw);
            e.done = (rem == 1);
            e.busy = busy;
            md_left = (rem > 0) ? rem - 1 : 0;
        end
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        cyc++;
    endtask

    task automatic check(input string name, input int c, input logic [1:0] act, input logic [1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got %b required %b", name, c, act, req);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares away from the active edge.
    initial begin
        exp_t e;
        int   c;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("StallF", c, {1'b0, hz.StallF}, {1'b0, e.sf});
                check("StallD", c, {1'b0, hz.StallD}, {1'b0, e.sd});
                check("StallE", c, {1'b0, hz.StallE}, {1'b0, e.se});
                check("FlushD", c, {1'b0, hz.FlushD}, {1'b0, e.fd});
                check("FlushE", c, {1'b0, hz.FlushE}, {1'b0, e.fe});
                check("FlushM", c, {1'b0, hz.FlushM}, {1'b0, e.fm});
                check("ForwardAE", c, hz.ForwardAE, e.fa);
                check("ForwardBE", c, hz.ForwardBE, e.fb);
                check("MulDivDoneE", c, {1'b0, hz.MulDivDoneE}, {1'b0, e.done});
                check("Busy", c, {1'b0, hz.Busy}, {1'b0, e.busy});
                $display("[TB] cyc %0d rst=%b exp=%b act=%b", c, reset, e,
                         {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM,
                          hz.ForwardAE, hz.ForwardBE, hz.MulDivDoneE, hz.Busy});
            end
        end
    end

    initial begin
        stim_t s;
        int    wait_cyc;
        reset = 1'b1;
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
        hz.RdE = '0; hz.RdM = '0; hz.RdW = '0; hz.ResultSrcE = '0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.PCSrcE = 1'b0;
        hz.MulDivStartE = 1'b0; hz.MulDivLatE = '0;

        // Reset with hazard-provoking inputs: outputs must still all be zero.
        s = quiet(); s.rst = 1'b1;
        apply(s);
        s.rs1e = 5'd7; s.rwm = 1'b1; s.rdm = 5'd7; s.pcsrc = 1'b1; s.start = 1'b1; s.lat = 6'd3;
        apply(s);

        // Load-use on x5, then the same with rd = x0.
        s = quiet(); s.rsrc = 2'b01; s.rde = 5'd5; s.rs1d = 5'd5;
        apply(s);
        s.rde = 5'd0; s.rs1d = 5'd0;
        apply(s);

        // Forwarding priority Memory over Writeback, then Writeback alone; operand B too.
        s = quiet(); s.rwm = 1'b1; s.rdm = 5'd7; s.rww = 1'b1; s.rdw = 5'd7; s.rs1e = 5'd7;
        apply(s);
        s.rwm = 1'b0;
        apply(s);
        s.rs2e = 5'd7; s.rwm = 1'b1; s.rdm = 5'd0; s.rs1e = 5'd0;
        apply(s);

        // Taken branch with nothing in flight.
        s = quiet(); s.pcsrc = 1'b1;
        apply(s);

        // L = 4, with a spurious start held high while busy.
        s = quiet(); s.start = 1'b1; s.lat = 6'd4;
        apply(s);
        s.lat = 6'd9;
        for (int i = 0; i < 3; i++) apply(s);
        s = quiet();
        apply(s);

        // Degenerate latencies.
        s = quiet(); s.start = 1'b1; s.lat = 6'd1;
        apply(s);
        s.lat = 6'd0;
        apply(s);
        s = quiet();
        apply(s);

        // L = 10 abandoned by reset on its 3rd cycle.
        s = quiet(); s.start = 1'b1; s.lat = 6'd10;
        apply(s);
        s.start = 1'b0;
        apply(s);
        s.rst = 1'b1;
        apply(s);
        s = quiet();
        for (int i = 0; i < 3; i++) apply(s);

        // Load-use and branch while mul/div stalls: flushes suppressed.
        s = quiet(); s.start = 1'b1; s.lat = 6'd3;
        apply(s);
        s = quiet(); s.rsrc = 2'b01; s.rde = 5'd4; s.rs2d = 5'd4; s.pcsrc = 1'b1;
        apply(s);
        apply(s);
        s = quiet();
        apply(s);

        // Maximum latency.
        s = quiet(); s.start = 1'b1; s.lat = 6'd63;
        apply(s);
        s = quiet();
        for (int i = 0; i < 64; i++) apply(s);

        // Randomized traffic over a small register set so hazards collide often.
        for (int i = 0; i < 500; i++) begin
            s.rst   = ($urandom_range(0, 59) == 0);
            s.rs1d  = 5'($urandom_range(0, 3));
            s.rs2d  = 5'($urandom_range(0, 3));
            s.rs1e  = 5'($urandom_range(0, 3));
            s.rs2e  = 5'($urandom_range(0, 3));
            s.rde   = 5'($urandom_range(0, 3));
            s.rdm   = 5'($urandom_range(0, 3));
            s.rdw   = 5'($urandom_range(0, 3));
            s.rsrc  = 2'($urandom_range(0, 3));
            s.rwm   = 1'($urandom_range(0, 1));
            s.rww   = 1'($urandom_range(0, 1));
            s.pcsrc = ($urandom_range(0, 4) == 0);
            s.start = ($urandom_range(0, 5) == 0);
            s.lat   = 6'($urandom_range(0, 12));
            apply(s);
        end

        s = quiet();
        apply(s);
        drv_done = 1'b1;

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
